// File: rtl/step_dir_generator_if.sv
// Command channel for step_dir_generator: one move per valid/ready handshake.
// The master presents direction, step count and step period; the slave
// raises cmd_ready only while it is idle.
interface step_dir_generator_if #(
  parameter int COUNT_BITS = 32,
  parameter int TICK_BITS  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_dir;
  logic [COUNT_BITS-1:0] cmd_steps;
  logic [TICK_BITS-1:0]  cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/step_dir_generator.sv
// step_dir_generator: timed step/dir pulse source for the stepper driver.
// Each accepted command emits cmd_steps pulses spaced cmd_period cycles apart
// (rising edge to rising edge), each high for max(pulse_width,1) cycles. A
// direction change inserts DIR_SETUP idle cycles before the first rising edge.
// The full period of the last step elapses before done, so back-to-back
// commands keep their spacing.
// Optional feature macro STEP_POSITION_EN adds a signed step position counter
// (output position, input pos_clear).
module step_dir_generator #(
  parameter int COUNT_BITS = 32,
  parameter int TICK_BITS  = 16,
  parameter int DIR_SETUP  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  step_dir_generator_if.slave   cmd,
  input  logic [TICK_BITS-1:0]  pulse_width,
  input  logic                  abort,
  output logic                  step,
  output logic                  dir,
  output logic                  busy,
  output logic                  done
`ifdef STEP_POSITION_EN
  ,
  input  logic                  pos_clear,
  output logic signed [COUNT_BITS:0] position
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  // Counter reload for the setup wait; tick counts down to zero inclusive.
  localparam logic [TICK_BITS-1:0] SETUP_LD =
    TICK_BITS'(DIR_SETUP > 0 ? DIR_SETUP - 1 : 0);
  localparam bit HAS_SETUP = (DIR_SETUP > 0);

  state_t                state_q, state_d;
  logic [TICK_BITS-1:0]  tick_q, tick_d;
  logic [COUNT_BITS-1:0] rem_q, rem_d;
  logic [TICK_BITS-1:0]  hw_q, lw_q;
  logic                  abort_pend_q;
  logic                  done_d;
  logic                  accept;
  logic                  enter_high;

  logic [TICK_BITS-1:0]  hw_in, lw_in;
  logic [TICK_BITS:0]    per_min, per_eff;

  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign step          = (state_q == S_HIGH);

  // Shape the incoming command: high width at least 1, period at least hw+1
  // so the low phase is never empty. One extra bit avoids overflow of hw+1.
  always_comb begin
    hw_in   = (pulse_width == '0) ? TICK_BITS'(1) : pulse_width;
    per_min = {1'b0, hw_in} + 1'b1;
    per_eff = ({1'b0, cmd.cmd_period} < per_min) ? per_min : {1'b0, cmd.cmd_period};
    lw_in   = TICK_BITS'(per_eff - {1'b0, hw_in});
  end

  // Next-state, counter reloads and done pulse.
  always_comb begin
    state_d    = state_q;
    tick_d     = (tick_q != '0) ? tick_q - 1'b1 : tick_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    enter_high = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd.cmd_steps == '0) begin
            done_d = 1'b1;
          end else if (HAS_SETUP && (cmd.cmd_dir != dir)) begin
            state_d = S_SETUP;
            tick_d  = SETUP_LD;
            rem_d   = cmd.cmd_steps;
          end else begin
            state_d    = S_HIGH;
            tick_d     = hw_in - 1'b1;
            rem_d      = cmd.cmd_steps - 1'b1;
            enter_high = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tick_q == '0) begin
          state_d    = S_HIGH;
          tick_d     = hw_q - 1'b1;
          rem_d      = rem_q - 1'b1;
          enter_high = 1'b1;
        end
      end
      S_HIGH: begin
        // An abort seen anywhere in the high phase lets it finish, then stops.
        if (tick_q == '0) begin
          if (abort || abort_pend_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOW;
            tick_d  = lw_q - 1'b1;
          end
        end
      end
      S_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tick_q == '0) begin
          if (rem_q != '0) begin
            state_d    = S_HIGH;
            tick_d     = hw_q - 1'b1;
            rem_d      = rem_q - 1'b1;
            enter_high = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, captured command timing and the dir level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      rem_q        <= '0;
      hw_q         <= '0;
      lw_q         <= '0;
      abort_pend_q <= 1'b0;
      dir          <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      rem_q        <= rem_d;
      done         <= done_d;
      abort_pend_q <= (state_q == S_HIGH) && (state_d == S_HIGH) && (abort || abort_pend_q);
      if (accept) begin
        dir  <= cmd.cmd_dir;
        hw_q <= hw_in;
        lw_q <= lw_in;
      end
    end
  end

`ifdef STEP_POSITION_EN
  localparam logic signed [COUNT_BITS:0] POS_ONE = 1;
  logic                        step_dir;
  logic signed [COUNT_BITS:0]  pos_base;

  // Direction of the pulse about to start; from IDLE dir is updated on the same edge.
  always_comb begin
    step_dir = (state_q == S_IDLE) ? cmd.cmd_dir : dir;
    pos_base = pos_clear ? '0 : position;
  end

  // Position follows each step rising edge; a clear on the same cycle applies first.
  always_ff @(posedge clk) begin
    if (reset) begin
      position <= '0;
    end else if (enter_high) begin
      position <= step_dir ? pos_base + POS_ONE : pos_base - POS_ONE;
    end else if (pos_clear) begin
      position <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_step_dir_generator.sv
// Bench for step_dir_generator: directed timing scenarios plus random traffic,
// checked every cycle against a timeline model (rise times, move end cycle).
module tb_step_dir_generator;
  localparam int CB = 32;
  localparam int TB = 16;
  localparam int DS = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [TB-1:0] pulse_width;
  logic          abort;
  logic          step, dir, busy, done;
`ifdef STEP_POSITION_EN
  logic               pos_clear;
  logic signed [CB:0] position;
`endif

  step_dir_generator_if #(.COUNT_BITS(CB), .TICK_BITS(TB)) ifc ();

  step_dir_generator #(.COUNT_BITS(CB), .TICK_BITS(TB), .DIR_SETUP(DS)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (ifc),
    .pulse_width (pulse_width),
    .abort       (abort),
    .step        (step),
    .dir         (dir),
    .busy        (busy),
    .done        (done)
`ifdef STEP_POSITION_EN
    ,
    .pos_clear   (pos_clear),
    .position    (position)
`endif
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  // Move timeline: accepted at m_n, first rise m_start, rises every m_p,
  // high m_hw cycles each, idle again (done) at m_end.
  longint m_n = 0, m_start = 0, m_end = -100, m_p = 1, m_hw = 1;
  bit     m_dir = 1'b0;
  bit     chk_en = 1'b0;

  task automatic check(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic checkv(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Model update from the inputs sampled at this edge.
  always @(posedge clk) begin : model
    longint t, hw, p, st, a_end, ph;
    t = cyc;
    if (reset) begin
      m_dir  <= 1'b0;
      m_end  <= -100;
      m_n    <= t;
      chk_en <= 1'b1;
    end else if (abort && t > m_n && t < m_end) begin
      if (t < m_start) a_end = t + 1;
      else begin
        ph    = (t - m_start) % m_p;
        a_end = (ph < m_hw) ? t - ph + m_hw : t + 1;
      end
      if (a_end < m_end) m_end <= a_end;
    end else if (ifc.cmd_valid && t >= m_end) begin
      hw = (pulse_width == 0) ? 1 : longint'(pulse_width);
      p  = (longint'(ifc.cmd_period) > hw) ? longint'(ifc.cmd_period) : hw + 1;
      m_n   <= t;
      m_dir <= ifc.cmd_dir;
      m_hw  <= hw;
      m_p   <= p;
      if (ifc.cmd_steps == 0) begin
        m_start <= t + 1;
        m_end   <= t + 1;
      end else begin
        st = t + 1 + ((ifc.cmd_dir != m_dir) ? DS : 0);
        m_start <= st;
        m_end   <= st + longint'(ifc.cmd_steps) * p;
      end
    end
    cyc <= t + 1;
  end

  // Per-cycle compare of every output against the timeline.
  always @(negedge clk) begin : compare
    longint t;
    bit eb, es, ed;
    if (chk_en) begin
      t  = cyc;
      eb = (t > m_n) && (t < m_end);
      es = eb && (t >= m_start) && (((t - m_start) % m_p) < m_hw);
      ed = (t == m_end);
      check("step", step, es);
      check("busy", busy, eb);
      check("ready", ifc.cmd_ready, !eb);
      check("done", done, ed);
      check("dir", dir, m_dir);
    end
  end

  // Trace of rising edges, done pulses and last high width for directed pins.
  longint rises[$];
  longint dones[$];
  int     hcnt = 0, last_w = 0;
  logic   prev_step = 1'b0;
  always @(negedge clk) begin : monitor
    if (step && !prev_step) rises.push_back(cyc);
    if (step) hcnt = prev_step ? hcnt + 1 : 1;
    else if (prev_step) last_w = hcnt;
    if (done) dones.push_back(cyc);
    prev_step = step;
  end

  task automatic clear_trace();
    rises.delete();
    dones.delete();
  endtask

  task automatic send(bit d, int s, int p, output longint n);
    bit ok = 1'b0;
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (ifc.cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout cyc=%0d", cyc);
    end else begin
      ifc.cmd_valid  = 1'b1;
      ifc.cmd_dir    = d;
      ifc.cmd_steps  = CB'(s);
      ifc.cmd_period = TB'(p);
      n = cyc;
      @(posedge clk); #1;
      ifc.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (ifc.cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout cyc=%0d", cyc);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    longint n;
    bit ab_ok;
    reset          = 1'b1;
    abort          = 1'b0;
    pulse_width    = TB'(2);
    ifc.cmd_valid  = 1'b0;
    ifc.cmd_dir    = 1'b0;
    ifc.cmd_steps  = '0;
    ifc.cmd_period = '0;
`ifdef STEP_POSITION_EN
    pos_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check("rst_step", step, 1'b0);
    check("rst_dir", dir, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", ifc.cmd_ready, 1'b1);

    // 3 pulses, 2 high / 8 low, no direction change.
    clear_trace();
    send(1'b0, 3, 10, n);
    wait_idle();
    checkv("t1_pulses", rises.size(), 3);
    if (rises.size() == 3) begin
      checkv("t1_first", rises[0] - n, 1);
      checkv("t1_gap", rises[2] - rises[1], 10);
      checkv("t1_done", dones[0] - rises[0], 30);
    end
    checkv("t1_width", last_w, 2);

    // Direction change: setup delay before the single pulse.
    clear_trace();
    send(1'b1, 1, 6, n);
    wait_idle();
    checkv("t2_pulses", rises.size(), 1);
    if (rises.size() == 1) begin
      checkv("t2_setup", rises[0] - n, 9);
      checkv("t2_done", dones[0] - rises[0], 6);
    end

    // Zero steps: done next cycle, nothing emitted.
    clear_trace();
    send(1'b0, 0, 5, n);
    wait_idle();
    checkv("t3_pulses", rises.size(), 0);
    checkv("t3_done", (dones.size() > 0) ? dones[0] - n : -1, 1);

    // Period clamp to hw+1, and pulse_width 0 -> 1 cycle high.
    clear_trace();
    pulse_width = TB'(5);
    send(1'b0, 2, 3, n);
    wait_idle();
    checkv("t4_width", last_w, 5);
    checkv("t4_gap", (rises.size() == 2) ? rises[1] - rises[0] : -1, 6);
    clear_trace();
    pulse_width = TB'(0);
    send(1'b0, 2, 4, n);
    wait_idle();
    checkv("t4_w1", last_w, 1);
    checkv("t4_gap1", (rises.size() == 2) ? rises[1] - rises[0] : -1, 4);

    // Abort during the high phase of pulse 5.
    clear_trace();
    pulse_width = TB'(2);
    send(1'b0, 100, 4, n);
    ab_ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rises.size() >= 5) begin ab_ok = 1'b1; break; end
    end
    checkv("t5_reached", ab_ok, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle();
    checkv("t5_pulses", rises.size(), 5);
    checkv("t5_done", (rises.size() == 5 && dones.size() > 0) ? dones[0] - rises[4] : -1, 2);

    // Reset mid-move.
    send(1'b1, 10, 5, n);
    repeat (12) @(posedge clk);
    pulse_reset();
    @(negedge clk); #1;
    check("rstmid_step", step, 1'b0);
    check("rstmid_dir", dir, 1'b0);

`ifdef STEP_POSITION_EN
    send(1'b1, 4, 4, n);
    wait_idle();
    send(1'b0, 2, 4, n);
    wait_idle();
    checkv("pos_net", position, 2);
    send(1'b1, 10, 4, n);
    repeat (10) @(posedge clk);
    pulse_reset();
    @(negedge clk); #1;
    checkv("pos_rst", position, 0);
    check("pos_rst_step", step, 1'b0);
`endif

    // Random traffic: commands, aborts, config changes and the odd reset.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      reset          = ($urandom_range(0, 299) == 0);
      abort          = ($urandom_range(0, 39) == 0);
      ifc.cmd_valid  = ($urandom_range(0, 2) == 0);
      ifc.cmd_dir    = 1'($urandom_range(0, 1));
      ifc.cmd_steps  = CB'($urandom_range(0, 5));
      ifc.cmd_period = TB'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) pulse_width = TB'($urandom_range(0, 6));
    end
    @(posedge clk); #1;
    reset         = 1'b0;
    abort         = 1'b0;
    ifc.cmd_valid = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
